inv_shift_rows: RTL and testbench

AES-128 row-permutation stage: applies the InvShiftRows byte permutation (FIPS-197 §5.3.1) to a 128-bit state, with a mode input that also selects the forward ShiftRows permutation. It is a single registered pipeline stage in the AES decrypt/encrypt round datapath. It sits between the SubBytes/InvSubBytes and AddRoundKey stages. It performs no arithmetic, only byte routing.

---
 rtl/inv_shift_rows.sv | 66 ++++++
 tb/tb_inv_shift_rows.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows.sv
// Purpose     : AES-128 (Inv)ShiftRows byte permutation over a column-major 128-bit state.
// Latency     : 1 cycle, registered outputs; one state accepted per cycle.
// Backpressure: none; a result is presented for exactly one cycle and is never stalled.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset; clears crypte and out_valid
//   in_valid  - message/inverse are valid this cycle
//   inverse   - 1 = InvShiftRows (row r rotates right by r), 0 = ShiftRows (left by r)
//   message   - input state, byte k = message[8k +: 8], bit 0 is MSB of byte 0
//   out_valid - crypte holds a new result this cycle
//   crypte    - permuted state, same byte numbering as message
module inv_shift_rows (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         inverse,
    input  logic [0:127] message,
    output logic         out_valid,
    output logic [0:127] crypte
);

    logic [0:127] perm_dat;
    logic [0:127] crypte_q;
    logic [0:127] crypte_d;
    logic         out_valid_q;
    logic         out_valid_d;

    // Byte k sits at row k%4, column k/4. Each output byte selects between two
    // fixed source bytes: the inverse source (column c-r) and the forward
    // source (column c+r), both wrapped modulo 4. Row 0 and row 2 pick the same
    // byte in both modes, so their mux collapses to a wire in synthesis.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int ROW     = k % 4;
        localparam int COL     = k / 4;
        localparam int INV_SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        localparam int FWD_SRC = 4 * ((COL + ROW) % 4) + ROW;

        assign perm_dat[8*k +: 8] = inverse ? message[8*INV_SRC +: 8]
                                            : message[8*FWD_SRC +: 8];
    end

    // Output register loads only on a valid input; otherwise the last result is held.
    always_comb begin
        crypte_d    = crypte_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            crypte_d    = perm_dat;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crypte_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            crypte_q    <= crypte_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign crypte    = crypte_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_shift_rows.sv
module tb_inv_shift_rows;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         inverse;
    logic [0:127] message;
    logic         out_valid;
    logic [0:127] crypte;

    inv_shift_rows dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .inverse  (inverse),
        .message  (message),
        .out_valid(out_valid),
        .crypte   (crypte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:127] msg;
        logic         inv;
        logic [0:127] exp;
    } vec_t;

    vec_t         tbl[$];
    logic [0:127] exp_q[$];
    logic [0:127] last_out;
    int           n_vec;
    int           n_err;

    // Reference: build s[r][c] explicitly, then rotate each row.
    function automatic logic [0:127] model(input logic [0:127] m, input logic inv);
        logic [7:0]   s [4][4];
        logic [0:127] o;
        int           src;
        o = '0;
        for (int k = 0; k < 16; k++) s[k % 4][k / 4] = m[8*k +: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[8*(4*c + r) +: 8] = s[r][src];
            end
        end
        return o;
    endfunction

    task automatic cmp_bit(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic cmp_dat(input string name, input logic [0:127] act, input logic [0:127] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic i, input logic [0:127] m);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        inverse  = i;
        message  = m;
    endtask

    // Drive one valid input, record its expectation, and check it one edge later.
    task automatic step_valid(input string name, input logic [0:127] m, input logic i,
                              input logic [0:127] e);
        logic [0:127] want;
        drive(1'b0, 1'b1, i, m);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmp_bit({name, "_vld"}, out_valid, 1'b1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: scoreboard empty, got %h", name, crypte);
        end else begin
            want = exp_q.pop_front();
            cmp_dat({name, "_dat"}, crypte, want);
            last_out = want;
        end
    endtask

    initial begin
        logic [0:127] rnd;
        logic [0:127] fwd;
        n_vec    = 0;
        n_err    = 0;
        last_out = '0;
        rst      = 1'b1;
        in_valid = 1'b1;
        inverse  = 1'b1;
        message  = 128'hffeeddccbbaa99887766554433221100;

        // Spec vectors, including the round trip of the forward ramp result.
        tbl.push_back('{128'h0123456789abcdef0123456789abcdef, 1'b1,
                        128'h01ab45ef8923cd6701ab45ef8923cd67});
        tbl.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                        128'h000d0a0704010e0b0805020f0c090603});
        tbl.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                        128'h00050a0f04090e03080d02070c01060b});
        tbl.push_back('{128'h00050a0f04090e03080d02070c01060b, 1'b1,
                        128'h000102030405060708090a0b0c0d0e0f});
        tbl.push_back('{128'h000d0a0704010e0b0805020f0c090603, 1'b0,
                        128'h000102030405060708090a0b0c0d0e0f});
        for (int j = 0; j < 4; j++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            tbl.push_back('{rnd, j[0], model(rnd, j[0])});
        end

        // Reset held two cycles with in_valid high.
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 1'b1, 1'b1, 128'hffeeddccbbaa99887766554433221100);
            @(posedge clk);
            #1;
            cmp_bit("reset_vld", out_valid, 1'b0);
            cmp_dat("reset_dat", crypte, 128'h0);
        end

        // Table vectors, back-to-back on consecutive cycles.
        foreach (tbl[j]) step_valid($sformatf("vec%0d", j), tbl[j].msg, tbl[j].inv, tbl[j].exp);

        // Random forward->inverse round trips stream through as identity.
        for (int j = 0; j < 3; j++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            fwd = model(rnd, 1'b0);
            step_valid($sformatf("rt_fwd%0d", j), rnd, 1'b0, fwd);
            step_valid($sformatf("rt_inv%0d", j), fwd, 1'b1, rnd);
        end

        // Idle: output held even while inverse and message toggle.
        for (int j = 0; j < 2; j++) begin
            drive(1'b0, 1'b0, j[0], {$urandom, $urandom, $urandom, $urandom});
            @(posedge clk);
            #1;
            cmp_bit("hold_vld", out_valid, 1'b0);
            cmp_dat("hold_dat", crypte, last_out);
        end

        // Mid-stream reset discards the valid input presented with it.
        step_valid("pre_rst", 128'h0123456789abcdef0123456789abcdef, 1'b1,
                   128'h01ab45ef8923cd6701ab45ef8923cd67);
        drive(1'b1, 1'b1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        @(posedge clk);
        #1;
        cmp_bit("midrst_vld", out_valid, 1'b0);
        cmp_dat("midrst_dat", crypte, 128'h0);
        step_valid("post_rst", 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                   128'h00050a0f04090e03080d02070c01060b);

        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        cmp_bit("end_vld", out_valid, 1'b0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
